// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Round controller for the AES-128 core. After a load request it
// sequences the key expansion block one round key at a time, and it steps
// the state datapath through these phases:
//    - the initial AddRoundKey;
//    - rounds 1..NUM_ROUNDS-1 (full rounds);
//    - the final round, which has no MixColumns.
// It owns the round counter and every round-key and state register write
// enable. It flags an error if key expansion fails to answer within
// KS_TIMEOUT cycles.
//
// Ports
//    int_osc      in   system clock
//    reset        in   synchronous active-high reset
//    load         in   start request, honoured only when not busy
//    ks_complete  in   key expansion has the next round key ready
//    round        out  current round index, feeds the key expansion counter
//    ks_load      out  one-cycle pulse requesting the next round key
//    key_sel      out  round-key mux select (0 input key, 1 expanded key)
//    rk_we        out  round-key register write enable
//    st_sel       out  state mux select (00 initial ARK, 01 full, 10 final)
//    st_we        out  state register write enable
//    busy         out  encryption in progress
//    done         out  ciphertext valid, held until the next load
//    err          out  key expansion timeout, held until the next load
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
   parameter int NUM_ROUNDS = 10,
   parameter int RW         = 4,
   parameter int KS_TIMEOUT = 64
) (
   input  logic          int_osc,
   input  logic          reset,
   input  logic          load,
   input  logic          ks_complete,
   output logic [RW-1:0] round,
   output logic          ks_load,
   output logic          key_sel,
   output logic          rk_we,
   output logic [1:0]    st_sel,
   output logic          st_we,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int TW = $clog2(KS_TIMEOUT + 1);

   localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);
   localparam logic [RW-1:0] FIRST_ROUND = RW'(1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(KS_TIMEOUT - 1);
   localparam logic [TW-1:0] WAIT_STEP = TW'(1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_INIT    = 3'd1;
   localparam logic [2:0] S_KS_REQ  = 3'd2;
   localparam logic [2:0] S_KS_WAIT = 3'd3;
   localparam logic [2:0] S_RK      = 3'd4;
   localparam logic [2:0] S_ST      = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;
   localparam logic [2:0] S_ERR     = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [RW-1:0] round_q, round_d;
   logic [TW-1:0] ksWaitCnt_q, ksWaitCnt_d;

   // Next-state logic.
   // Load is only honoured from the resting states, so a request that
   // arrives mid-encryption neither restarts nor disturbs the round count.
   // Restarting clears the round index so that INIT presents round 0.
   // The key-expansion wait counter is cleared on every request. While
   // waiting, the counter advances on each cycle that passes without
   // ks_complete. The KS_TIMEOUT-th such cycle gives up and moves to ERR,
   // leaving the round index frozen at the round that failed.
   always_comb begin
      state_d     = state_q;
      round_d     = round_q;
      ksWaitCnt_d = ksWaitCnt_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (load) begin
               state_d = S_INIT;
               round_d = '0;
            end
         end
         S_INIT: begin
            round_d = FIRST_ROUND;
            state_d = S_KS_REQ;
         end
         S_KS_REQ: begin
            ksWaitCnt_d = '0;
            state_d     = S_KS_WAIT;
         end
         S_KS_WAIT: begin
            if (ks_complete) begin
               state_d = S_RK;
            end else if (ksWaitCnt_q == WAIT_LAST) begin
               state_d = S_ERR;
            end else begin
               ksWaitCnt_d = ksWaitCnt_q + WAIT_STEP;
            end
         end
         S_RK: begin
            state_d = S_ST;
         end
         S_ST: begin
            if (round_q == LAST_ROUND) begin
               state_d = S_DONE;
            end else begin
               round_d = round_q + FIRST_ROUND;
               state_d = S_KS_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
            round_d = '0;
         end
      endcase
   end

   // State, round and wait-counter registers with synchronous reset.
   always_ff @(posedge int_osc) begin
      if (reset) begin
         state_q     <= S_IDLE;
         round_q     <= '0;
         ksWaitCnt_q <= '0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         ksWaitCnt_q <= ksWaitCnt_d;
      end
   end

   // Moore output decode from the registered state and round only.
   // INIT writes both the round-key and state registers from the input
   // key. In the ST state, the final round is recognised by the round index
   // rather than by a separate state.
   always_comb begin
      ks_load = 1'b0;
      key_sel = 1'b0;
      rk_we   = 1'b0;
      st_sel  = 2'b00;
      st_we   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      case (state_q)
         S_INIT: begin
            rk_we = 1'b1;
            st_we = 1'b1;
            busy  = 1'b1;
         end
         S_KS_REQ: begin
            ks_load = 1'b1;
            busy    = 1'b1;
         end
         S_KS_WAIT: begin
            busy = 1'b1;
         end
         S_RK: begin
            rk_we   = 1'b1;
            key_sel = 1'b1;
            busy    = 1'b1;
         end
         S_ST: begin
            st_we  = 1'b1;
            st_sel = (round_q == LAST_ROUND) ? 2'b10 : 2'b01;
            busy   = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         S_ERR: begin
            err = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign round = round_q;

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Top-level round controller for the AES-128 core. It sequences the key expansion FSM one round key at a time and steps the state datapath through the initial AddRoundKey, rounds 1..9 and the final round. It sits between the SPI load/done handshake and the keyexpansion/round datapath. It owns the round counter and all register write enables.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds after initial AddRoundKey
RW, 4, width of round counter (must hold NUM_ROUNDS)
KS_TIMEOUT, 64, max cycles to wait for ks_complete before flagging error

Ports:
int_osc  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  start request from SPI; sampled only in IDLE, DONE, ERR
ks_complete  in  1  keyexpansion has valid nextkey for requested round
round  out  RW  current round index; drives keyexpansion counter input
ks_load  out  1  one-cycle pulse starting key expansion for round
key_sel  out  1  round-key mux: 0 = input key, 1 = keyexpansion nextkey
rk_we  out  1  round-key register write enable
st_sel  out  2  state mux: 00 = plaintext^key, 01 = full round, 10 = final round (no MixColumns)
st_we  out  1  state register write enable
busy  out  1  high from INIT through last ST
done  out  1  ciphertext valid; level, held in DONE
err  out  1  key expansion timeout; level, held in ERR

Behaviour:
- Reset (sync, active-high, at any time incl. mid-operation): state=IDLE, round=0, ks_load=rk_we=st_we=key_sel=0, st_sel=00, busy=done=err=0, timeout counter=0.
- Moore FSM. All outputs decode from registered state/round.
- IDLE: all enables 0. load=1 -> INIT.
- INIT (1 cycle): round=0, rk_we=1, key_sel=0, st_we=1, st_sel=00. Next: round<=1, -> KS_REQ.
- KS_REQ (1 cycle): ks_load=1. Timeout counter cleared. -> KS_WAIT.
- KS_WAIT (>=1 cycle): ks_complete is sampled from the first cycle.
  - ks_complete=1 -> RK.
  - Otherwise the counter increments. On reaching KS_TIMEOUT with no complete -> ERR.
  - The keyexpansion block must drop ks_complete on the ks_load cycle. A stale high is not filtered.
- RK (1 cycle): rk_we=1, key_sel=1. -> ST.
- ST (1 cycle): st_we=1; st_sel=10 if round==NUM_ROUNDS else 01.
  - round==NUM_ROUNDS -> DONE.
  - Otherwise round<=round+1, -> KS_REQ.
- DONE: done=1, busy=0, round holds NUM_ROUNDS. load=1 -> INIT, done drops the same edge.
- ERR: err=1, busy=0, round frozen at the failing value. load=1 -> INIT, err clears.
- load while busy: ignored, no restart, no effect on round.
- ks_complete outside KS_WAIT: ignored.
- round never exceeds NUM_ROUNDS and never wraps.
- Latency, with W = KS_WAIT cycles per round:
  - Edge sampling load enters INIT.
  - DONE is entered 1 + NUM_ROUNDS*(3+W) edges later: 41 for W=1, 51 for W=2.
- Exactly NUM_ROUNDS ks_load pulses, NUM_ROUNDS+1 rk_we pulses and NUM_ROUNDS+1 st_we pulses per encryption.

Test Plan:
- Nominal: reset 2 cycles, load pulse 1 cycle, ks_complete model answers 1 cycle after ks_load -> 10 ks_load pulses with round=1..10; st_sel=00 once, 01 x9, 10 x1; done rises at edge 41, busy low after.
- FIPS-197 end-to-end: key 2B7E151628AED2A6ABF7158809CF4F3C, plaintext 3243F6A8885A308D313198A2E0370734 with real keyexpansion/datapath -> ciphertext 3925841D02DC09FBDC118597196A0B32 when done=1.
- Timeout: ks_complete stuck 0 in round 3 -> err=1 after 64 KS_WAIT cycles, round=3, busy=0, no further ks_load; then load -> err=0, restart from INIT.
- Load while busy: load asserted in round 5 -> ignored, round sequence and done timing unchanged.
- Reset mid-operation: reset in round 7 KS_WAIT -> next edge IDLE, all outputs 0; ks_complete afterwards has no effect.
- Back-to-back and stale complete: load held high in DONE -> immediate restart (done low next edge); ks_complete pulsed during RK/ST -> ignored, counts unchanged.
